// File: rtl/tff_cnt_pkg.sv
// Shared definitions for the T-flip-flop modulo counter: direction codes and
// the modulo next-count function used by the toggle generator.
package tff_cnt_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Next count value for a modulo-`modulus` counter stepping in direction up_dn.
  function automatic int next_count(input int q, input logic up_dn, input int modulus);
    if (up_dn == DIR_UP) begin
      return (q == modulus - 1) ? 0 : q + 1;
    end else begin
      return (q == 0) ? modulus - 1 : q - 1;
    end
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop storage cell with asynchronous active-high reset.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= q ^ t;
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter with parallel load. State lives in T cells; a
// combinational toggle generator flips exactly the bits that change.
module tff_mod_counter
  import tff_cnt_pkg::*;
#(
  parameter  int MODULUS = 10,
  localparam int W       = $clog2(MODULUS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic [W-1:0] qb,
  output logic         tc,
  output logic         load_err
);

  localparam logic [W-1:0] MAX_COUNT = W'(MODULUS - 1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_b;
  logic [W-1:0] next_q;
  logic [W-1:0] t;
  logic         load_ok;

  assign load_ok = (int'(load_val) < MODULUS);

  // Load has priority over counting; an out-of-range load parks the count at 0.
  always_comb begin
    next_q = cnt;
    if (load) begin
      next_q = load_ok ? load_val : '0;
    end else if (en) begin
      next_q = W'(next_count(int'(cnt), up_dn, MODULUS));
    end
  end

  assign t = next_q ^ cnt;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_cell
      tff_cell u_cell (
        .clk (clk),
        .rst (rst),
        .t   (t[gi]),
        .q   (cnt[gi]),
        .qb  (cnt_b[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err <= 1'b0;
    end else if (load && !load_ok) begin
      load_err <= 1'b1;
    end
  end

  assign tc = en & (((up_dn == DIR_UP) & (cnt == MAX_COUNT)) |
                    ((up_dn == DIR_DN) & (cnt == '0)));

  assign q  = cnt;
  assign qb = cnt_b;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Scoreboard bench for tff_mod_counter: MODULUS=10 main instance plus a
// MODULUS=16 instance for the full-width wrap.
module tb_tff_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] q, qb;
  logic       tc, load_err;

  logic       en16, up16, load16;
  logic [3:0] lv16;
  logic [3:0] q16, qb16;
  logic       tc16, err16;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int q;
    int err;
  } exp_t;
  exp_t sb[$];

  int mq;
  int merr;

  tff_mod_counter #(.MODULUS(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q), .qb(qb), .tc(tc), .load_err(load_err)
  );

  tff_mod_counter #(.MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .up_dn(up16), .load(load16),
    .load_val(lv16), .q(q16), .qb(qb16), .tc(tc16), .load_err(err16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // One clock of stimulus on the MODULUS=10 instance: check tc before the
  // edge, push the model's prediction, then pop and compare after the edge.
  task automatic cyc(input string tag, input logic l, input logic e,
                     input logic u, input int lv);
    exp_t ex;
    int   exp_tc;
    @(negedge clk);
    load     = l;
    en       = e;
    up_dn    = u;
    load_val = 4'(lv);
    #1;
    exp_tc = (e && ((u && mq == 9) || (!u && mq == 0))) ? 1 : 0;
    chk({tag, "_tc"}, int'(tc), exp_tc);
    if (l) begin
      if (lv < 10) mq = lv;
      else begin
        mq   = 0;
        merr = 1;
      end
    end else if (e) begin
      mq = u ? (mq + 1) % 10 : (mq + 9) % 10;
    end
    ex.q   = mq;
    ex.err = merr;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    chk({tag, "_q"},   int'(q),        ex.q);
    chk({tag, "_qb"},  int'(qb),       (~ex.q) & 15);
    chk({tag, "_err"}, int'(load_err), ex.err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int prev16;
    rst = 1'b1; en = 0; up_dn = 1; load = 0; load_val = 0;
    en16 = 0; up16 = 1; load16 = 0; lv16 = 0;
    mq = 0; merr = 0;

    // reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_q",   int'(q),        0);
    chk("rst_qb",  int'(qb),       15);
    chk("rst_err", int'(load_err), 0);
    chk("rst_tc",  int'(tc),       0);
    chk("rst_q16", int'(q16),      0);
    rst = 1'b0;

    // 1: count up 12 edges, wrap 9 -> 0
    for (int i = 0; i < 12; i++) cyc($sformatf("up%0d", i), 0, 1, 1, 0);

    // 2: from 0 count down 3 edges
    cyc("ld0", 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc($sformatf("dn%0d", i), 0, 1, 0, 0);

    // 3: load beats enable
    cyc("ld4",    1, 0, 1, 4);
    cyc("ld7en",  1, 1, 1, 7);
    cyc("after7", 0, 1, 1, 0);

    // 4: illegal load sets sticky error; legal load does not clear it
    cyc("ld12", 1, 0, 1, 12);
    cyc("ld3",  1, 0, 1, 3);
    cyc("cnt3", 0, 1, 1, 0);

    // 5: async reset mid-count
    cyc("ld5",  1, 0, 1, 5);
    cyc("to6",  0, 1, 1, 0);
    @(negedge clk);
    en = 0; load = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_q",   int'(q),        0);
    chk("arst_err", int'(load_err), 0);
    mq = 0; merr = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("hold%0d", i), 0, 0, 1, 0);

    // 6: MODULUS=16 wrap, all bits toggle
    @(negedge clk);
    load16 = 1; lv16 = 4'd14;
    @(posedge clk); #1;
    chk("m16_ld14", int'(q16), 14);
    @(negedge clk);
    load16 = 0; en16 = 1; up16 = 1;
    #1 chk("m16_tc14", int'(tc16), 0);
    @(posedge clk); #1;
    chk("m16_q15",  int'(q16),  15);
    chk("m16_tc15", int'(tc16), 1);
    chk("m16_qb15", int'(qb16), 0);
    prev16 = int'(q16);
    @(posedge clk); #1;
    chk("m16_wrap",   int'(q16), 0);
    chk("m16_toggle", int'(q16) ^ prev16, 15);
    chk("m16_err",    int'(err16), 0);
    en16 = 0;

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
